// File: rtl/axis_cmd_gen_mm2s.sv
// axis_cmd_gen_mm2s
// Plays a DDR buffer back onto a stream by issuing DataMover MM2S commands.
// The buffer [base_addr, base_addr+play_size) is split into chunks of at most
// MAX_BURST_LEN bytes. The block consumes the MM2S status stream, counts
// outstanding commands, flags bad status and can optionally loop the playback.
module axis_cmd_gen_mm2s #(
  parameter int BTT_WIDTH       = 23,
  parameter int MAX_BURST_LEN   = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [71:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [7:0]  s_axis_sts_tdata,
  input  logic        s_axis_sts_tvalid,
  output logic        s_axis_sts_tready,
  input  logic        read_start,
  input  logic        read_reset,
  input  logic        loop_en,
  input  logic [31:0] base_addr,
  input  logic [31:0] play_size,
  output logic        play_busy,
  output logic        play_done,
  output logic        sts_err,
  output logic [3:0]  outstanding
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND_CMD   = 2'd1,
    ST_WAIT_READY = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

  localparam logic [31:0] MAX_LEN_C = 32'(MAX_BURST_LEN);
  localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUTSTANDING);

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] remaining_r;
  logic [31:0] base_r;
  logic [31:0] size_r;
  logic [3:0]  tag_r;
  logic [3:0]  outstanding_r;
  logic        play_done_r;
  logic        sts_err_r;
  logic [71:0] tdata_r;
  logic        tvalid_r;

  logic [31:0] xfer_s;
  logic        last_s;
  logic [71:0] cmd_s;
  logic        cmd_hs_s;
  logic        sts_hs_s;

  // The status channel is always able to accept, except while held in reset.
  assign s_axis_sts_tready = ~reset;

  assign cmd_hs_s = tvalid_r & m_axis_tready;
  assign sts_hs_s = s_axis_sts_tvalid & s_axis_sts_tready;

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign play_busy     = (state_r != ST_IDLE);
  assign play_done     = play_done_r;
  assign sts_err       = sts_err_r;
  assign outstanding   = outstanding_r;

  // Chunk size for the next command and the command word built from it.
  always_comb begin
    if (remaining_r > MAX_LEN_C) begin
      xfer_s = MAX_LEN_C;
      last_s = 1'b0;
    end else begin
      xfer_s = remaining_r;
      last_s = 1'b1;
    end
    cmd_s = {4'h0, tag_r, addr_r, 1'b0, last_s, 6'h00, 1'b1,
             23'(xfer_s[BTT_WIDTH-1:0])};
  end

  // Outstanding command counter: +1 per command, -1 per status, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r <= 4'd0;
    end else if (read_reset) begin
      outstanding_r <= 4'd0;
    end else if (cmd_hs_s && !sts_hs_s) begin
      if (outstanding_r != 4'hF) begin
        outstanding_r <= outstanding_r + 4'd1;
      end else begin
        outstanding_r <= outstanding_r;
      end
    end else if (sts_hs_s && !cmd_hs_s) begin
      if (outstanding_r != 4'd0) begin
        outstanding_r <= outstanding_r - 4'd1;
      end else begin
        outstanding_r <= outstanding_r;
      end
    end else begin
      outstanding_r <= outstanding_r;
    end
  end

  // Playback FSM: command issue, handshake, loop reload, drain and status error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'd0;
      remaining_r <= 32'd0;
      base_r      <= 32'd0;
      size_r      <= 32'd0;
      tag_r       <= 4'd0;
      play_done_r <= 1'b0;
      sts_err_r   <= 1'b0;
      tdata_r     <= 72'd0;
      tvalid_r    <= 1'b0;
    end else if (read_reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'd0;
      remaining_r <= 32'd0;
      base_r      <= 32'd0;
      size_r      <= 32'd0;
      tag_r       <= 4'd0;
      play_done_r <= 1'b0;
      sts_err_r   <= 1'b0;
      tdata_r     <= 72'd0;
      tvalid_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (read_start && !play_done_r) begin
            addr_r      <= base_addr;
            remaining_r <= play_size;
            base_r      <= base_addr;
            size_r      <= play_size;
            sts_err_r   <= 1'b0;
            if (play_size == 32'd0) begin
              play_done_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              state_r     <= ST_SEND_CMD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND_CMD: begin
          if (sts_err_r) begin
            state_r <= ST_DRAIN;
          end else if (outstanding_r < MAX_OUT_C) begin
            tdata_r  <= cmd_s;
            tvalid_r <= 1'b1;
            state_r  <= ST_WAIT_READY;
          end else begin
            state_r <= ST_SEND_CMD;
          end
        end
        ST_WAIT_READY: begin
          if (m_axis_tready) begin
            tvalid_r <= 1'b0;
            tag_r    <= tag_r + 4'd1;
            if (!last_s) begin
              addr_r      <= addr_r + xfer_s;
              remaining_r <= remaining_r - xfer_s;
              state_r     <= ST_SEND_CMD;
            end else if (loop_en) begin
              addr_r      <= base_r;
              remaining_r <= size_r;
              state_r     <= ST_SEND_CMD;
            end else begin
              addr_r      <= addr_r + xfer_s;
              remaining_r <= 32'd0;
              state_r     <= ST_DRAIN;
            end
          end else begin
            state_r <= ST_WAIT_READY;
          end
        end
        ST_DRAIN: begin
          if (outstanding_r == 4'd0) begin
            play_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
        end
      endcase
      // Any status beat without OKAY latches the error flag.
      if (sts_hs_s && !s_axis_sts_tdata[7]) begin
        sts_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_cmd_gen_mm2s.sv
// Directed testbench for axis_cmd_gen_mm2s (instantiated with MAX_OUTSTANDING=2).
module tb_axis_cmd_gen_mm2s;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [71:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [7:0]  s_axis_sts_tdata = 8'h00;
  logic        s_axis_sts_tvalid = 1'b0;
  logic        s_axis_sts_tready;
  logic        read_start = 1'b0;
  logic        read_reset = 1'b0;
  logic        loop_en = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [31:0] play_size = 32'd0;
  logic        play_busy;
  logic        play_done;
  logic        sts_err;
  logic [3:0]  outstanding;

  int errors = 0;
  int checks = 0;

  axis_cmd_gen_mm2s #(
    .BTT_WIDTH(23), .MAX_BURST_LEN(4096), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset(reset),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_sts_tdata(s_axis_sts_tdata), .s_axis_sts_tvalid(s_axis_sts_tvalid),
    .s_axis_sts_tready(s_axis_sts_tready),
    .read_start(read_start), .read_reset(read_reset), .loop_en(loop_en),
    .base_addr(base_addr), .play_size(play_size),
    .play_busy(play_busy), .play_done(play_done), .sts_err(sts_err), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Expected command word, assembled from the documented field layout.
  function automatic logic [71:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                         input logic eof, input logic [22:0] btt);
    return {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, btt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_axis_tvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (play_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic send_sts(input logic [7:0] d);
    s_axis_sts_tdata  = d;
    s_axis_sts_tvalid = 1'b1;
    step();
    s_axis_sts_tvalid = 1'b0;
    s_axis_sts_tdata  = 8'h00;
  endtask

  task automatic soft_reset();
    read_reset = 1'b1;
    step();
    read_reset = 1'b0;
  endtask

  task automatic start_pass(input logic [31:0] b, input logic [31:0] s);
    base_addr  = b;
    play_size  = s;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 72'd0 || play_busy !== 1'b0 ||
        play_done !== 1'b0 || sts_err !== 1'b0 || outstanding !== 4'd0)
      begin errors++; $display("FAIL reset_outputs: got tvalid=%b tdata=%h busy=%b done=%b err=%b out=%0d, need all zero",
                               m_axis_tvalid, m_axis_tdata, play_busy, play_done, sts_err, outstanding); end
    checks++;
    if (s_axis_sts_tready !== 1'b0)
      begin errors++; $display("FAIL reset_sts_tready: got %b need 0", s_axis_sts_tready); end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (s_axis_sts_tready !== 1'b1)
      begin errors++; $display("FAIL run_sts_tready: got %b need 1", s_axis_sts_tready); end
  endtask

  task automatic test_basic();
    logic [71:0] exp_c [3];
    logic ok;
    exp_c[0] = mk_cmd(4'd0, 32'h8000_0000, 1'b0, 23'd4096);
    exp_c[1] = mk_cmd(4'd1, 32'h8000_1000, 1'b0, 23'd4096);
    exp_c[2] = mk_cmd(4'd2, 32'h8000_2000, 1'b1, 23'd1808);
    m_axis_tready = 1'b1;
    start_pass(32'h8000_0000, 32'd10000);
    checks++;
    if (m_axis_tvalid !== 1'b0 || play_busy !== 1'b1)
      begin errors++; $display("FAIL basic_first_edge: got tvalid=%b busy=%b need 0/1", m_axis_tvalid, play_busy); end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b1)
      begin errors++; $display("FAIL basic_tvalid_latency: got tvalid=%b need 1", m_axis_tvalid); end
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_cmd%0d_timeout: got no tvalid need tvalid", k); end
      checks++;
      if (m_axis_tdata !== exp_c[k])
        begin errors++; $display("FAIL basic_cmd%0d: got %h need %h", k, m_axis_tdata, exp_c[k]); end
      step();
      if (k == 0) begin
        checks++;
        if (m_axis_tvalid !== 1'b0 || outstanding !== 4'd1)
          begin errors++; $display("FAIL basic_gap: got tvalid=%b out=%0d need 0/1", m_axis_tvalid, outstanding); end
      end
      send_sts(8'h80 | 8'(k));
    end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got play_done=0 need 1"); end
    checks++;
    if (outstanding !== 4'd0 || play_busy !== 1'b0 || sts_err !== 1'b0)
      begin errors++; $display("FAIL basic_end: got out=%0d busy=%b err=%b need 0/0/0", outstanding, play_busy, sts_err); end
  endtask

  task automatic test_backpressure();
    logic [71:0] exp_c [3];
    logic ok;
    exp_c[0] = mk_cmd(4'd0, 32'h8000_0000, 1'b0, 23'd4096);
    exp_c[1] = mk_cmd(4'd1, 32'h8000_1000, 1'b0, 23'd4096);
    exp_c[2] = mk_cmd(4'd2, 32'h8000_2000, 1'b1, 23'd1808);
    soft_reset();
    m_axis_tready = 1'b1;
    start_pass(32'h8000_0000, 32'd10000);
    wait_valid(ok);
    checks++;
    if (!ok || m_axis_tdata !== exp_c[0])
      begin errors++; $display("FAIL bp_cmd0: got ok=%b %h need %h", ok, m_axis_tdata, exp_c[0]); end
    step();
    m_axis_tready = 1'b0;
    send_sts(8'h80);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_c[1])
        begin errors++; $display("FAIL bp_hold%0d: got tvalid=%b %h need 1 %h", i, m_axis_tvalid, m_axis_tdata, exp_c[1]); end
      step();
    end
    m_axis_tready = 1'b1;
    step();
    send_sts(8'h81);
    wait_valid(ok);
    checks++;
    if (!ok || m_axis_tdata !== exp_c[2])
      begin errors++; $display("FAIL bp_cmd2: got ok=%b %h need %h", ok, m_axis_tdata, exp_c[2]); end
    step();
    send_sts(8'h82);
    wait_done(ok);
    checks++;
    if (!ok || outstanding !== 4'd0)
      begin errors++; $display("FAIL bp_done: got done=%b out=%0d need 1/0", play_done, outstanding); end
  endtask

  task automatic test_outstanding();
    logic ok;
    soft_reset();
    m_axis_tready = 1'b1;
    start_pass(32'h1000_0000, 32'd16384);
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok || m_axis_tdata !== mk_cmd(4'(k), 32'h1000_0000 + 32'(k) * 32'h1000, 1'b0, 23'd4096))
        begin errors++; $display("FAIL out_cmd%0d: got ok=%b %h", k, ok, m_axis_tdata); end
      step();
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b0 || outstanding !== 4'd2)
        begin errors++; $display("FAIL out_stall%0d: got tvalid=%b out=%0d need 0/2", i, m_axis_tvalid, outstanding); end
      step();
    end
    send_sts(8'h80);
    wait_valid(ok);
    checks++;
    if (!ok || m_axis_tdata !== mk_cmd(4'd2, 32'h1000_2000, 1'b0, 23'd4096))
      begin errors++; $display("FAIL out_cmd2: got ok=%b %h", ok, m_axis_tdata); end
    step();
    send_sts(8'h81);
    wait_valid(ok);
    checks++;
    if (!ok || m_axis_tdata !== mk_cmd(4'd3, 32'h1000_3000, 1'b1, 23'd4096))
      begin errors++; $display("FAIL out_cmd3: got ok=%b %h", ok, m_axis_tdata); end
    step();
    send_sts(8'h82);
    send_sts(8'h83);
    wait_done(ok);
    checks++;
    if (!ok || outstanding !== 4'd0)
      begin errors++; $display("FAIL out_done: got done=%b out=%0d need 1/0", play_done, outstanding); end
    read_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (play_busy !== 1'b0 || m_axis_tvalid !== 1'b0 || play_done !== 1'b1)
        begin errors++; $display("FAIL no_retrigger%0d: got busy=%b tvalid=%b done=%b need 0/0/1", i, play_busy, m_axis_tvalid, play_done); end
    end
    read_start = 1'b0;
  endtask

  task automatic test_sts_err();
    logic ok;
    soft_reset();
    m_axis_tready = 1'b1;
    start_pass(32'h0000_0000, 32'd16384);
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok || m_axis_tdata !== mk_cmd(4'(k), 32'(k) * 32'h1000, 1'b0, 23'd4096))
        begin errors++; $display("FAIL err_cmd%0d: got ok=%b %h", k, ok, m_axis_tdata); end
      step();
    end
    send_sts(8'h41);
    checks++;
    if (sts_err !== 1'b1 || outstanding !== 4'd1)
      begin errors++; $display("FAIL err_flag: got err=%b out=%0d need 1/1", sts_err, outstanding); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b0 || play_done !== 1'b0)
        begin errors++; $display("FAIL err_nocmd%0d: got tvalid=%b done=%b need 0/0", i, m_axis_tvalid, play_done); end
      step();
    end
    send_sts(8'h81);
    wait_done(ok);
    checks++;
    if (!ok || sts_err !== 1'b1 || outstanding !== 4'd0)
      begin errors++; $display("FAIL err_done: got done=%b err=%b out=%0d need 1/1/0", play_done, sts_err, outstanding); end
  endtask

  task automatic test_loop();
    logic ok;
    soft_reset();
    m_axis_tready = 1'b1;
    loop_en = 1'b1;
    start_pass(32'h2000_0000, 32'd4096);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      if (k == 2) loop_en = 1'b0;
      checks++;
      if (!ok || m_axis_tdata !== mk_cmd(4'(k), 32'h2000_0000, 1'b1, 23'd4096))
        begin errors++; $display("FAIL loop_cmd%0d: got ok=%b %h", k, ok, m_axis_tdata); end
      step();
      send_sts(8'h80 | 8'(k));
    end
    wait_done(ok);
    checks++;
    if (!ok || m_axis_tvalid !== 1'b0 || play_busy !== 1'b0)
      begin errors++; $display("FAIL loop_stop: got done=%b tvalid=%b busy=%b need 1/0/0", play_done, m_axis_tvalid, play_busy); end
  endtask

  task automatic test_zero_and_reset();
    logic ok;
    soft_reset();
    start_pass(32'h3000_0000, 32'd0);
    checks++;
    if (play_done !== 1'b1 || play_busy !== 1'b0 || m_axis_tvalid !== 1'b0)
      begin errors++; $display("FAIL zero_size: got done=%b busy=%b tvalid=%b need 1/0/0", play_done, play_busy, m_axis_tvalid); end
    soft_reset();
    checks++;
    if (play_done !== 1'b0)
      begin errors++; $display("FAIL soft_reset_done: got %b need 0", play_done); end
    m_axis_tready = 1'b1;
    start_pass(32'h0000_0000, 32'd16384);
    wait_valid(ok);
    step();
    m_axis_tready = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || m_axis_tdata !== mk_cmd(4'd1, 32'h0000_1000, 1'b0, 23'd4096) || outstanding !== 4'd1)
      begin errors++; $display("FAIL midpass_cmd1: got ok=%b %h out=%0d", ok, m_axis_tdata, outstanding); end
    soft_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 72'd0 || outstanding !== 4'd0 ||
        play_busy !== 1'b0 || play_done !== 1'b0 || sts_err !== 1'b0)
      begin errors++; $display("FAIL midpass_reset: got tvalid=%b tdata=%h out=%0d busy=%b done=%b err=%b need all zero",
                               m_axis_tvalid, m_axis_tdata, outstanding, play_busy, play_done, sts_err); end
    m_axis_tready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_outstanding();
    test_sts_err();
    test_loop();
    test_zero_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
